// File: rtl/nano_sequencer.sv
// nano_sequencer: fetch/decode/execute control unit of the 8-bit nanoprocessor.
// Fetches an opcode byte (and an operand byte for 2-byte instructions) through
// the PC, then issues one cycle of datapath strobes in EXEC.
//
// Handshake/strobe semantics: every output strobe is a single-cycle,
// combinational pulse decoded from the current state, the latched opcode and
// the flags. A strobe is acted on by the datapath at the rising edge that ends
// the cycle in which it is high. There is no backpressure.
module nano_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int OPC_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  z_flag,
  input  logic                  c_flag,
  output logic                  addr_sel,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  inc_PC,
  output logic                  load_PC,
  output logic                  load_ACC,
  output logic [1:0]            acc_src,
  output logic [1:0]            alu_op,
  output logic                  load_flags,
  output logic                  write_mem,
  output logic                  halted,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    EXEC      = 2'd2,
    HALTED    = 2'd3
  } state_t;

  localparam logic [OPC_WIDTH-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_WIDTH-1:0] OP_LDA  = 4'h1;
  localparam logic [OPC_WIDTH-1:0] OP_STA  = 4'h2;
  localparam logic [OPC_WIDTH-1:0] OP_ADD  = 4'h3;
  localparam logic [OPC_WIDTH-1:0] OP_SUB  = 4'h4;
  localparam logic [OPC_WIDTH-1:0] OP_AND  = 4'h5;
  localparam logic [OPC_WIDTH-1:0] OP_JMP  = 4'h6;
  localparam logic [OPC_WIDTH-1:0] OP_JZ   = 4'h7;
  localparam logic [OPC_WIDTH-1:0] OP_JC   = 4'h8;
  localparam logic [OPC_WIDTH-1:0] OP_LDI  = 4'h9;
  localparam logic [OPC_WIDTH-1:0] OP_HALT = 4'hF;

  state_t                state, state_next;
  // Only the opcode field of IR is kept; the low nibble never affects decode.
  logic [OPC_WIDTH-1:0]  ir;
  logic [DATA_WIDTH-1:0] arg;
  logic [OPC_WIDTH-1:0]  fetch_opc;

  assign fetch_opc = mem_data[DATA_WIDTH-1 -: OPC_WIDTH];
  assign operand   = arg;
  assign halted    = (state == HALTED);
  assign dbg_state = state;

  // State, IR and ARG registers; IR/ARG load only in their own fetch state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH_OP;
      ir    <= '0;
      arg   <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH_OP)  ir  <= fetch_opc;
      if (state == FETCH_ARG) arg <= mem_data;
    end
  end

  // Next-state decode and strobe generation; reset suppresses every strobe.
  always_comb begin
    state_next = state;
    addr_sel   = 1'b0;
    inc_PC     = 1'b0;
    load_PC    = 1'b0;
    load_ACC   = 1'b0;
    acc_src    = 2'd0;
    alu_op     = 2'd0;
    load_flags = 1'b0;
    write_mem  = 1'b0;
    case (state)
      FETCH_OP: begin
        inc_PC = 1'b1;
        if (fetch_opc == OP_HALT) begin
          state_next = HALTED;
        end else if (fetch_opc == OP_NOP || fetch_opc > OP_LDI) begin
          // NOP and the illegal opcodes A-E are single-byte no-ops.
          state_next = FETCH_OP;
        end else begin
          state_next = FETCH_ARG;
        end
      end
      FETCH_ARG: begin
        inc_PC     = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        state_next = FETCH_OP;
        case (ir)
          OP_LDA: begin
            addr_sel = 1'b1;
            load_ACC = 1'b1;
            acc_src  = 2'd1;
          end
          OP_LDI: begin
            load_ACC = 1'b1;
            acc_src  = 2'd2;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            addr_sel   = 1'b1;
            load_ACC   = 1'b1;
            load_flags = 1'b1;
            alu_op     = (ir == OP_SUB) ? 2'd1 : (ir == OP_AND) ? 2'd2 : 2'd0;
          end
          OP_STA: begin
            addr_sel  = 1'b1;
            write_mem = 1'b1;
          end
          OP_JMP:  load_PC = 1'b1;
          OP_JZ:   load_PC = z_flag;
          OP_JC:   load_PC = c_flag;
          default: ;
        endcase
      end
      HALTED: state_next = HALTED;
      default: state_next = FETCH_OP;
    endcase
    if (reset) begin
      addr_sel   = 1'b0;
      inc_PC     = 1'b0;
      load_PC    = 1'b0;
      load_ACC   = 1'b0;
      load_flags = 1'b0;
      write_mem  = 1'b0;
    end
  end

endmodule

// File: tb/tb_nano_sequencer.sv
// Directed bench for nano_sequencer: a small PC + memory model feeds mem_data,
// and each cycle's strobes are compared with hand-computed values.
module tb_nano_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] mem_data;
  logic       z_flag = 1'b0;
  logic       c_flag = 1'b0;
  logic       addr_sel;
  logic [7:0] operand;
  logic       inc_PC, load_PC, load_ACC, load_flags, write_mem, halted;
  logic [1:0] acc_src, alu_op, dbg_state;

  logic [7:0] mem [256];
  logic [7:0] pc;
  int         n_cmp = 0;
  int         n_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  nano_sequencer dut (
    .clk(clk), .reset(reset), .mem_data(mem_data), .z_flag(z_flag),
    .c_flag(c_flag), .addr_sel(addr_sel), .operand(operand), .inc_PC(inc_PC),
    .load_PC(load_PC), .load_ACC(load_ACC), .acc_src(acc_src), .alu_op(alu_op),
    .load_flags(load_flags), .write_mem(write_mem), .halted(halted),
    .dbg_state(dbg_state)
  );

  // PC register and asynchronous-read memory that sit around the sequencer
  always_ff @(posedge clk) begin
    if (reset)        pc <= 8'h00;
    else if (load_PC) pc <= operand;
    else if (inc_PC)  pc <= pc + 8'h01;
  end
  assign mem_data = addr_sel ? mem[operand] : mem[pc];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // {addr_sel, inc_PC, load_PC, load_ACC, load_flags, write_mem}
  function automatic logic [7:0] strobes();
    return {2'b00, addr_sel, inc_PC, load_PC, load_ACC, load_flags, write_mem};
  endfunction

  // advance one clock; check the exclusivity invariants in the new cycle
  task automatic step();
    @(posedge clk);
    #1;
    chk("excl_pc", {7'd0, inc_PC & load_PC}, 8'h00);
    chk("excl_mem", {7'd0, write_mem & load_ACC}, 8'h00);
  endtask

  task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = b0;
    mem[1] = b1;
    mem[2] = b2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    #1;
    chk("rst_strobes", strobes(), 8'h00);
    step();
    reset = 1'b0;
    #1;
    chk("rst_state", {6'd0, dbg_state}, 8'd0);
    chk("rst_operand", operand, 8'h00);
    chk("rst_halted", {7'd0, halted}, 8'h00);
  endtask

  // run a 2-byte instruction up to its EXEC cycle, checking both fetch cycles
  task automatic run_to_exec(input string tag);
    chk({tag, "_fop"}, strobes(), 8'h10);
    step();
    chk({tag, "_farg_st"}, {6'd0, dbg_state}, 8'd1);
    chk({tag, "_farg"}, strobes(), 8'h10);
    step();
    chk({tag, "_exec_st"}, {6'd0, dbg_state}, 8'd2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // 1. LDI 05
    load_prog(8'h90, 8'h05, 8'h00);
    do_reset();
    run_to_exec("ldi");
    chk("ldi_strobes", strobes(), 8'h04);
    chk("ldi_src", {6'd0, acc_src}, 8'd2);
    chk("ldi_operand", operand, 8'h05);
    step();
    chk("ldi_pc", pc, 8'h02);
    chk("ldi_next_st", {6'd0, dbg_state}, 8'd0);

    // 2. JMP A5
    load_prog(8'h60, 8'hA5, 8'h00);
    do_reset();
    run_to_exec("jmp");
    chk("jmp_strobes", strobes(), 8'h08);
    chk("jmp_operand", operand, 8'hA5);
    step();
    chk("jmp_pc", pc, 8'hA5);
    chk("jmp_next_st", {6'd0, dbg_state}, 8'd0);

    // 3. JZ / JC, flag low then high
    for (int f = 0; f < 4; f++) begin
      load_prog((f < 2) ? 8'h70 : 8'h80, 8'h33, 8'h00);
      do_reset();
      z_flag = (f == 1);
      c_flag = (f == 3);
      run_to_exec("jcc");
      chk("jcc_load_pc", {7'd0, load_PC}, {7'd0, f[0]});
      chk("jcc_inc_pc", {7'd0, inc_PC}, 8'h00);
      chk("jcc_operand", operand, 8'h33);
      step();
      chk("jcc_pc", pc, f[0] ? 8'h33 : 8'h02);
      z_flag = 1'b0;
      c_flag = 1'b0;
    end

    // 4. STA 40, then SUB 41
    load_prog(8'h20, 8'h40, 8'h00);
    do_reset();
    run_to_exec("sta");
    chk("sta_strobes", strobes(), 8'h21);
    chk("sta_operand", operand, 8'h40);
    load_prog(8'h40, 8'h41, 8'h00);
    do_reset();
    run_to_exec("sub");
    chk("sub_strobes", strobes(), 8'h26);
    chk("sub_alu_op", {6'd0, alu_op}, 8'd1);
    chk("sub_acc_src", {6'd0, acc_src}, 8'd0);

    // 5. NOP, illegal B7, HALT
    load_prog(8'h00, 8'hB7, 8'hF0);
    do_reset();
    chk("nop_strobes", strobes(), 8'h10);
    step();
    chk("ill_st", {6'd0, dbg_state}, 8'd0);
    chk("ill_pc", pc, 8'h01);
    chk("ill_strobes", strobes(), 8'h10);
    step();
    chk("hlt_fetch_pc", pc, 8'h02);
    chk("hlt_fetch", strobes(), 8'h10);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hlt_halted", {7'd0, halted}, 8'h01);
      chk("hlt_strobes", strobes(), 8'h00);
    end
    chk("hlt_pc", pc, 8'h03);
    do_reset();
    chk("hlt_exit_st", {6'd0, dbg_state}, 8'd0);

    // 6. reset during EXEC of ADD 10
    load_prog(8'h30, 8'h10, 8'h00);
    do_reset();
    run_to_exec("add");
    chk("add_strobes", strobes(), 8'h26);
    reset = 1'b1;
    #1;
    chk("add_rst_strobes", strobes(), 8'h00);
    step();
    reset = 1'b0;
    #1;
    chk("add_rst_st", {6'd0, dbg_state}, 8'd0);
    chk("add_rst_operand", operand, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
